// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: shares one external fixed-latency FP add/sub unit between two requesters.
//
// Parameters:
//   LATENCY     cycles from fa_a/fa_b/fa_sub stable to fa_out valid (0..6)
//   FIFO_DEPTH  result buffer entries, must be >= LATENCY+1
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   reqN_valid/reqN_ready            requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sub         requester N operands, sub=1 selects A-B
//   fa_a, fa_b, fa_sub               registered operands driven to the shared adder
//   fa_out, fa_zflag                 adder result and zero flag
//   rsp_valid/rsp_ready              response handshake
//   rsp_result, rsp_zflag, rsp_tag   response payload, tag = requester index
//   busy                             an operation is in flight or buffered
//
// Configuration macro FPADD_ARB_RR_EN: when defined, ties alternate round-robin;
// when undefined, requester 0 always wins a tie.
module fpadd_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = LATENCY + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [31:0] fa_a,
  output logic [31:0] fa_b,
  output logic        fa_sub,
  input  logic [31:0] fa_out,
  input  logic        fa_zflag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zflag,
  output logic        rsp_tag,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

  // Credits cover buffered plus in-flight results, so a granted op always has a slot.
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LATENCY:0] vld_q, vld_d, tag_q, tag_d;
  logic [33:0] mem_q [FIFO_DEPTH];

  logic space, gnt0, gnt1, acc0, acc1, acc, push, pop;

  // Grant depends only on registered credits, never on rsp_ready.
  assign space = credit_q < DEPTH_C;

`ifdef FPADD_ARB_RR_EN
  logic last_q;  // last granted requester; reset to 1 so requester 0 wins the first tie

  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (acc) begin
      last_q <= acc1;
    end
  end
`else
  assign gnt1 = req1_valid & ~req0_valid;
`endif

  assign gnt0       = req0_valid & ~gnt1;
  assign req0_ready = rst_n & space & gnt0;
  assign req1_ready = rst_n & space & gnt1;
  assign acc0       = req0_ready;
  assign acc1       = req1_ready;
  assign acc        = acc0 | acc1;

  // Result for the op accepted LATENCY+1 edges ago is on fa_out now.
  assign push = vld_q[LATENCY];
  assign pop  = rsp_valid & rsp_ready;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    for (int i = LATENCY; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    vld_d[0] = acc;
    tag_d[0] = acc1;
  end

  always_comb begin
    credit_d = credit_q;
    if (acc && !pop) begin
      credit_d = credit_q + CW'(1);
    end else if (!acc && pop) begin
      credit_d = credit_q - CW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
    wr_d = wr_q;
    if (push) begin
      wr_d = (wr_q == LAST_IDX) ? '0 : wr_q + PW'(1);
    end
    rd_d = rd_q;
    if (pop) begin
      rd_d = (rd_q == LAST_IDX) ? '0 : rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      vld_q    <= '0;
      tag_q    <= '0;
      fa_a     <= '0;
      fa_b     <= '0;
      fa_sub   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      if (acc0) begin
        fa_a   <= req0_a;
        fa_b   <= req0_b;
        fa_sub <= req0_sub;
      end else if (acc1) begin
        fa_a   <= req1_a;
        fa_b   <= req1_b;
        fa_sub <= req1_sub;
      end
    end
  end

  // Storage needs no reset: entries are only visible while cnt_q is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {tag_q[LATENCY], fa_zflag, fa_out};
    end
  end

  assign rsp_valid = cnt_q != '0;
  assign {rsp_tag, rsp_zflag, rsp_result} = rsp_valid ? mem_q[rd_q] : 34'd0;
  assign busy = (|vld_q) | rsp_valid;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: directed vector table plus hand-written multi-cycle sequences
// for fpadd_arbiter, with a stand-in fixed-latency adder and a response scoreboard.
module tb_fpadd_arbiter;

  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic [31:0] fa_a, fa_b, fa_out;
  logic        fa_sub, fa_zflag;
  logic        rsp_valid, rsp_ready, rsp_zflag, rsp_tag, busy;
  logic [31:0] rsp_result;

  always #5 clk = ~clk;

  fpadd_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub),
    .fa_a(fa_a), .fa_b(fa_b), .fa_sub(fa_sub), .fa_out(fa_out), .fa_zflag(fa_zflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zflag(rsp_zflag), .rsp_tag(rsp_tag), .busy(busy)
  );

  // Stand-in adder: known IEEE vectors return hand-computed sums, anything else a
  // deterministic scramble so ordering and tagging can still be tracked.
  function automatic logic [32:0] fa_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
    logic [31:0] r;
    if (a == 32'h400CCCCC && b == 32'h3F8CCCCC && !sub) return {1'b0, 32'h40533332};
    if (a == 32'h3E800000 && b == 32'h3F400000 && sub)  return {1'b0, 32'hBF000000};
    if (a == 32'h0 && b == 32'h0)                       return {1'b1, 32'h0};
    r = a ^ {b[15:0], b[31:16]} ^ {31'b0, sub};
    return {r == 32'h0, r};
  endfunction

  logic [32:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= fa_model(fa_a, fa_b, fa_sub);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign {fa_zflag, fa_out} = pipe_q[LAT-1];

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    bit          sub;
    logic [31:0] res;
    bit          z;
  } vec_t;

  vec_t        vecs [4];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [33:0] sb [$];
  bit          grants [$];
  bit          acc0_seen, acc1_seen, valid_seen, ready0_seen, stall;
  logic [34:0] held;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit port, input bit v, input logic [31:0] a,
                       input logic [31:0] b, input bit sub);
    if (!port) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  // Sample mid-cycle (negedge + 1), score handshakes, then advance to the next negedge.
  task automatic cycle();
    #1;
    check("ready_excl", {63'b0, req0_ready & req1_ready}, 64'd0);
    check("busy", {63'b0, busy}, {63'b0, sb.size() != 0});
    if (stall) check("rsp_hold", {29'b0, rsp_valid, rsp_tag, rsp_zflag, rsp_result},
                     {29'b0, held});
    stall       = rsp_valid & ~rsp_ready & rst_n;
    held        = {rsp_valid, rsp_tag, rsp_zflag, rsp_result};
    valid_seen  = rsp_valid;
    ready0_seen = req0_ready;
    if (rsp_valid && rsp_ready && rst_n) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_order: got response %0h required none", rsp_result);
      end else begin
        check("rsp_order", {30'b0, rsp_tag, rsp_zflag, rsp_result}, {30'b0, sb.pop_front()});
        pops++;
      end
    end
    acc0_seen = req0_valid & req0_ready & rst_n;
    acc1_seen = req1_valid & req1_ready & rst_n;
    if (acc0_seen) begin
      sb.push_back({1'b0, fa_model(req0_a, req0_b, req0_sub)});
      grants.push_back(1'b0);
    end
    if (acc1_seen) begin
      sb.push_back({1'b1, fa_model(req1_a, req1_b, req1_sub)});
      grants.push_back(1'b1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    sb.delete();
    stall = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int t = 0; t < 60 && sb.size() != 0; t++) cycle();
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int  lat, n0, n1, p0;
    bit  got;
    vecs[0] = '{port: 1'b0, a: 32'h400CCCCC, b: 32'h3F8CCCCC, sub: 1'b0, res: 32'h40533332,
                z: 1'b0};
    vecs[1] = '{port: 1'b1, a: 32'h3E800000, b: 32'h3F400000, sub: 1'b1, res: 32'hBF000000,
                z: 1'b0};
    vecs[2] = '{port: 1'b1, a: 32'h0, b: 32'h0, sub: 1'b1, res: 32'h0, z: 1'b1};
    vecs[3] = '{port: 1'b0, a: 32'h0, b: 32'h0, sub: 1'b1, res: 32'h0, z: 1'b1};

    stall = 1'b0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h400CCCCC, 32'h3F8CCCCC, 1'b0);  // valid during reset must not grant
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_req0_ready", {63'b0, req0_ready}, 64'd0);
    check("rst_req1_ready", {63'b0, req1_ready}, 64'd0);
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_rsp_payload", {30'b0, rsp_tag, rsp_zflag, rsp_result}, 64'd0);
    check("rst_fa", {31'b0, fa_sub, fa_a}, 64'd0);
    check("rst_fa_b", {32'b0, fa_b}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    cycle();

    // Directed vectors: latency, payload and tag against hand-computed values.
    foreach (vecs[k]) begin
      drive(vecs[k].port, 1'b1, vecs[k].a, vecs[k].b, vecs[k].sub);
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        cycle();
        got = vecs[k].port ? acc1_seen : acc0_seen;
      end
      drive(vecs[k].port, 1'b0, 32'h0, 32'h0, 1'b0);
      check("vec_accept", {63'b0, got}, 64'd1);
      lat = 0;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        cycle();
        lat++;
        got = valid_seen;
      end
      check("vec_latency", lat - 1, LAT + 1);
      check("vec_result", {32'b0, rsp_result}, {32'b0, vecs[k].res});
      check("vec_zflag", {63'b0, rsp_zflag}, {63'b0, vecs[k].z});
      check("vec_tag", {63'b0, rsp_tag}, {63'b0, vecs[k].port});
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
    end

    // Both requesters busy for 8 ops each.
    do_reset();
    grants.delete();
    rsp_ready = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int t = 0; t < 80 && (n0 < 8 || n1 < 8); t++) begin
      drive(1'b0, n0 < 8, 32'h1000 + n0, 32'h0F0F0000 + n0, n0[0]);
      drive(1'b1, n1 < 8, 32'h8000 + n1, 32'h00F00F00 + n1, n1[0]);
      cycle();
      if (acc0_seen) n0++;
      if (acc1_seen) n1++;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rr_count0", n0, 8);
    check("rr_count1", n1, 8);
    check("rr_grants", grants.size(), 16);
    for (int i = 0; i < 16 && i < grants.size(); i++) begin
`ifdef FPADD_ARB_RR_EN
      check("rr_grant_seq", {63'b0, grants[i]}, i % 2);
`else
      check("rr_grant_seq", {63'b0, grants[i]}, {63'b0, i >= 8});
`endif
    end
    drain();

    // Response backpressure: credits must stop grants at exactly DEPTH.
    rsp_ready = 1'b0;
    n0 = 0;
    for (int t = 0; t < 20; t++) begin
      drive(1'b0, 1'b1, 32'h2000 + n0, 32'h55 + n0, 1'b0);
      cycle();
      if (acc0_seen) n0++;
    end
    check("bp_accepts", n0, DEPTH);
    check("bp_ready_low", {63'b0, ready0_seen}, 64'd0);
    p0 = pops;
    rsp_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      drive(1'b0, 1'b1, 32'h2000 + n0, 32'h55 + n0, 1'b0);
      cycle();
      if (acc0_seen) n0++;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drain();
    check("bp_no_loss", pops - p0, n0);

    // Reset with two ops in flight: late adder outputs must be dropped.
    rsp_ready = 1'b0;
    n0 = 0;
    for (int t = 0; t < 2; t++) begin
      drive(1'b0, 1'b1, 32'h3000 + t, 32'h77, 1'b1);
      cycle();
      if (acc0_seen) n0++;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_mid_accepts", n0, 2);
    do_reset();
    for (int t = 0; t < 6; t++) begin
      cycle();
      check("rst_mid_rsp_valid", {63'b0, valid_seen}, 64'd0);
    end
    check("final_busy", {63'b0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: fixed cycles from FA_A/FA_B/FA_SUB stable to FA_OUT valid; legal 0..6.
REQ-002 Parameter FIFO_DEPTH, default LATENCY+2: result buffer entries; SHALL be at least LATENCY+1.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 REQ0_VALID, REQ1_VALID  in  1 each  requester operation present.
REQ-006 REQ0_READY, REQ1_READY  out  1 each  grant; the operation is accepted on an edge where VALID and READY are both high.
REQ-007 REQ0_A, REQ0_B, REQ1_A, REQ1_B  in  32 each  IEEE-754 single-precision operands.
REQ-008 REQ0_SUB, REQ1_SUB  in  1 each  1 = A-B, 0 = A+B.
REQ-009 FA_A, FA_B  out  32 each  operands to the shared FP add/sub unit; FA_SUB  out  1  op select.
REQ-010 FA_OUT  in  32  adder result; FA_ZFLAG  in  1  adder zero flag.
REQ-011 RSP_VALID  out  1; RSP_READY  in  1  response handshake.
REQ-012 RSP_RESULT  out  32; RSP_ZFLAG  out  1; RSP_TAG  out  1  requester index of the response.
REQ-013 BUSY  out  1  high while any operation is in flight or buffered.

Function
REQ-014 Credit count = FIFO occupancy + in-flight ops; a grant SHALL be issued only when the registered count < FIFO_DEPTH.
REQ-015 A pop SHALL free its credit from the next cycle; no combinational path from RSP_READY to REQx_READY.
REQ-016 At most one REQx_READY SHALL be high per cycle; READY to a requester with VALID low is permitted but has no effect.
REQ-017 Both VALID high: grant the requester not granted last (pointer updates only on an accepted op); one VALID high: grant it.
REQ-018 On accept at edge E, operands and SUB SHALL be registered onto FA_A/FA_B/FA_SUB and held until the next accept.
REQ-019 FA_OUT/FA_ZFLAG SHALL be sampled at edge E+LATENCY+1 and pushed with the tag; RSP_VALID is high from then on. Minimum accept-to-RSP_VALID latency is LATENCY+1 cycles.
REQ-020 In-flight tracking: LATENCY+1-deep valid/tag shift register; back-to-back accepts every cycle SHALL be supported.
REQ-021 Responses SHALL be returned in accept order; RSP_* stable while RSP_VALID high and RSP_READY low.
REQ-022 Pop on RSP_VALID & RSP_READY; a simultaneous push and pop SHALL leave occupancy unchanged, including at full.
REQ-023 BUSY = in-flight nonzero OR FIFO nonempty.

Reset
REQ-024 While RST_N is low at an edge: FIFO empty, in-flight cleared, arbitration pointer set so REQ0 wins the first tie.
REQ-025 Reset values: REQx_READY 0, RSP_VALID 0, RSP_RESULT 0, RSP_ZFLAG 0, RSP_TAG 0, FA_A 0, FA_B 0, FA_SUB 0, BUSY 0.
REQ-026 Reset mid-operation SHALL discard in-flight and buffered results; adder outputs arriving after reset SHALL be ignored.

Configuration
REQ-027 Macro FPADD_ARB_RR_EN defined: round-robin per REQ-017. Undefined: fixed priority, REQ0 always wins ties, pointer logic removed.

Verification
REQ-028 REQ0 A=0x400CCCCC B=0x3F8CCCCC SUB=0, LATENCY=2 -> RSP_VALID 3 cycles after accept, RESULT=0x40533332, TAG=0, ZFLAG=0.
REQ-029 REQ1 A=0x3E800000 B=0x3F400000 SUB=1 -> RESULT=0xBF000000, TAG=1; A=B=0 SUB=1 -> RESULT=0x00000000, ZFLAG=1.
REQ-030 Both VALID held high for 8 ops each, RSP_READY=1 -> grants alternate 0,1,0,1...; with FPADD_ARB_RR_EN undefined all REQ0 first.
REQ-031 RSP_READY=0 while issuing continuously -> exactly FIFO_DEPTH accepts then READY low; raise RSP_READY -> in-order drain, no loss.
REQ-032 RST_N low for 1 cycle with 2 ops in flight -> RSP_VALID stays 0, BUSY 0, late FA_OUT not buffered.
